// File: rtl/remap_cmd_ctrl.sv
// Remap command controller: queues port-remap commands and issues them one at a
// time to the downstream swap stage, holding off while the address decode is busy.
module remap_cmd_ctrl #(
    parameter int N_INIT_PORT   = 8,
    parameter int LOG_N_INIT    = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid_i,
    output logic                              cmd_ready_o,
    input  logic [LOG_N_INIT-1:0]             cmd_source_i,
    input  logic [LOG_N_INIT-1:0]             cmd_target_i,
    input  logic                              bus_busy_i,
    output logic                              select_o,
    output logic [LOG_N_INIT-1:0]             source_o,
    output logic [LOG_N_INIT-1:0]             target_o,
    output logic [N_INIT_PORT*LOG_N_INIT-1:0] map_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending_o,
    output logic                              err_o,
    output logic                              done_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         settle_cnt_q, settle_cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [LOG_N_INIT-1:0] src_mem_q [FIFO_DEPTH];
    logic [LOG_N_INIT-1:0] src_mem_d [FIFO_DEPTH];
    logic [LOG_N_INIT-1:0] tgt_mem_q [FIFO_DEPTH];
    logic [LOG_N_INIT-1:0] tgt_mem_d [FIFO_DEPTH];
    logic [LOG_N_INIT-1:0] map_q [N_INIT_PORT];
    logic [LOG_N_INIT-1:0] map_d [N_INIT_PORT];
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  cmd_bad;
    logic                  push;
    logic                  pop;
    logic [LOG_N_INIT-1:0] head_src;
    logic [LOG_N_INIT-1:0] head_tgt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready depends only on the registered count, never on cmd_valid_i.
    assign cmd_ready_o = (int'(count_q) < FIFO_DEPTH);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign cmd_bad     = (int'(cmd_source_i) >= N_INIT_PORT) ||
                         (int'(cmd_target_i) >= N_INIT_PORT);
    assign push        = accept && !cmd_bad;
    assign pop         = (state_q == ISSUE);
    assign head_src    = src_mem_q[rd_ptr_q];
    assign head_tgt    = tgt_mem_q[rd_ptr_q];

    always_comb begin
        src_mem_d = src_mem_q;
        tgt_mem_d = tgt_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            src_mem_d[wr_ptr_q] = cmd_source_i;
            tgt_mem_d[wr_ptr_q] = cmd_target_i;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !bus_busy_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d      = SETTLE;
                settle_cnt_d = '0;
                done_d       = (SETTLE_CYCLES == 1);
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                    done_d       = (settle_cnt_d == SETTLE_LAST);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The shadow map follows what the swap stage is told at the edge closing ISSUE.
    always_comb begin
        map_d = map_q;
        if (pop) begin
            for (int i = 0; i < N_INIT_PORT; i++) begin
                if (head_src == LOG_N_INIT'(i)) begin
                    map_d[i] = head_tgt;
                end
            end
        end
    end

    assign err_d = accept && cmd_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                src_mem_q[i] <= '0;
                tgt_mem_q[i] <= '0;
            end
            for (int i = 0; i < N_INIT_PORT; i++) begin
                map_q[i] <= LOG_N_INIT'(i);
            end
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
            done_q       <= done_d;
            src_mem_q    <= src_mem_d;
            tgt_mem_q    <= tgt_mem_d;
            map_q        <= map_d;
        end
    end

    assign select_o  = (state_q == ISSUE);
    assign source_o  = select_o ? head_src : '0;
    assign target_o  = select_o ? head_tgt : '0;
    assign pending_o = count_q;
    assign err_o     = err_q;
    assign done_o    = done_q;

    for (genvar g = 0; g < N_INIT_PORT; g++) begin : g_map
        assign map_o[g*LOG_N_INIT +: LOG_N_INIT] = map_q[g];
    end

endmodule

// File: tb/tb_remap_cmd_ctrl.sv
// Bench for remap_cmd_ctrl: directed scenarios plus randomized traffic, checked by
// a negedge monitor against an in-order expectation queue and a shadow map model.
module tb_remap_cmd_ctrl;

    localparam int N      = 6;
    localparam int LOG    = 3;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;
    localparam int CW     = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid_i = 1'b0;
    logic               cmd_ready_o;
    logic [LOG-1:0]     cmd_source_i = '0;
    logic [LOG-1:0]     cmd_target_i = '0;
    logic               bus_busy_i = 1'b0;
    logic               select_o;
    logic [LOG-1:0]     source_o;
    logic [LOG-1:0]     target_o;
    logic [N*LOG-1:0]   map_o;
    logic [CW-1:0]      pending_o;
    logic               err_o;
    logic               done_o;

    remap_cmd_ctrl #(
        .N_INIT_PORT(N), .LOG_N_INIT(LOG), .FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_source_i(cmd_source_i), .cmd_target_i(cmd_target_i), .bus_busy_i(bus_busy_i),
        .select_o(select_o), .source_o(source_o), .target_o(target_o), .map_o(map_o),
        .pending_o(pending_o), .err_o(err_o), .done_o(done_o)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    int               checks = 0;
    int               failures = 0;
    logic [2*LOG-1:0] exp_q[$];
    int               err_exp_q[$];
    int               sel_cycles[$];
    int               model_map[N];
    int               acc_cnt = 0;
    int               sel_cnt = 0;
    int               last_sel = -100;
    logic             prev_bus = 1'b0;
    bit               rand_bus = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N*LOG-1:0] exp_map();
        logic [N*LOG-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[i*LOG +: LOG] = LOG'(model_map[i]);
        return m;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        err_exp_q.delete();
        sel_cycles.delete();
        for (int i = 0; i < N; i++) model_map[i] = i;
        acc_cnt  = 0;
        sel_cnt  = 0;
        last_sel = -100;
    endtask

    // monitor
    always @(negedge clk) begin
        if (rst_n) begin
            logic [2*LOG-1:0] e;
            bit exp_err;
            chk("pending", int'(pending_o), acc_cnt - sel_cnt);
            chk("ready", int'(cmd_ready_o), int'((acc_cnt - sel_cnt) < DEPTH));
            chk("map", int'(map_o), int'(exp_map()));
            chk("done", int'(done_o), int'(cyc == last_sel + SETTLE));
            exp_err = (err_exp_q.size() > 0) && (err_exp_q[0] == cyc);
            chk("err", int'(err_o), int'(exp_err));
            while (err_exp_q.size() > 0 && err_exp_q[0] <= cyc) void'(err_exp_q.pop_front());
            if (select_o) begin
                chk("bus_idle_before_issue", int'(prev_bus), 0);
                if (last_sel >= 0) chk("spacing_min", int'(cyc - last_sel >= SETTLE + 2), 1);
                chk("select_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("source", int'(source_o), int'(e[2*LOG-1:LOG]));
                    chk("target", int'(target_o), int'(e[LOG-1:0]));
                    model_map[e[2*LOG-1:LOG]] = int'(e[LOG-1:0]);
                end
                last_sel = cyc;
                sel_cnt++;
                sel_cycles.push_back(cyc);
            end else begin
                chk("idle_src_tgt", int'({source_o, target_o}), 0);
            end
        end
        prev_bus = bus_busy_i;
    end

    always @(posedge clk) begin
        #1;
        if (rand_bus) bus_busy_i = ($urandom_range(0, 2) == 0);
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input int src, input int tgt);
        int waitc = 0;
        cmd_valid_i  = 1'b1;
        cmd_source_i = LOG'(src);
        cmd_target_i = LOG'(tgt);
        while (!cmd_ready_o && waitc < 200) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!cmd_ready_o) begin
            chk("push_ready_timeout", int'(cmd_ready_o), 1);
            cmd_valid_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        if (src >= N || tgt >= N) begin
            err_exp_q.push_back(cyc);
        end else begin
            exp_q.push_back({LOG'(src), LOG'(tgt)});
            acc_cnt++;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_pending", int'(pending_o), 0);
        chk("rst_ready", int'(cmd_ready_o), 1);
        chk("rst_select", int'(select_o), 0);
        chk("rst_src_tgt", int'({source_o, target_o}), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_map", int'(map_o), int'(exp_map()));
    endtask

    initial begin : watchdog
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stimulus
        int a;
        int waitc;
        model_reset();
        rst_n = 1'b0;
        idle(3);
        check_reset_outputs();
        rst_n = 1'b1;
        idle(2);

        // single command latency, map update
        sel_cycles.delete();
        push(1, 3);
        a = cyc;
        idle(10);
        chk("lat_sel_count", sel_cycles.size(), 1);
        if (sel_cycles.size() > 0) chk("lat_sel_cycle", sel_cycles[0], a + 1);
        chk("map_entry1", int'(map_o[1*LOG +: LOG]), 3);

        // out-of-range indices rejected
        sel_cycles.delete();
        push(7, 2);
        push(2, 6);
        push(6, 6);
        push(4, 4);
        idle(10);
        chk("err_only_legal_sel", sel_cycles.size(), 1);

        // fill under bus busy, fifth offered command refused
        sel_cycles.delete();
        bus_busy_i = 1'b1;
        push(0, 5); push(5, 0); push(2, 2); push(3, 1);
        chk("full_ready", int'(cmd_ready_o), 0);
        chk("full_pending", int'(pending_o), DEPTH);
        cmd_valid_i = 1'b1; cmd_source_i = 3'd1; cmd_target_i = 3'd1;
        idle(3);
        cmd_valid_i = 1'b0;
        chk("full_pending_after", int'(pending_o), DEPTH);
        idle(5);
        chk("busy_no_select", sel_cycles.size(), 0);
        bus_busy_i = 1'b0;
        idle(4 * (SETTLE + 2) + 4);
        chk("drain_sel_count", sel_cycles.size(), 4);

        // back-to-back issues with bus toggling outside IDLE
        sel_cycles.delete();
        push(1, 4); push(4, 1); push(0, 0);
        for (int i = 0; i < 12; i++) begin
            bus_busy_i = (i == 2 || (i > 2 && (i - 2) % 4 == 0)) ? 1'b0 : 1'b1;
            idle(1);
        end
        bus_busy_i = 1'b0;
        idle(4);
        chk("b2b_sel_count", sel_cycles.size(), 3);
        for (int i = 1; i < sel_cycles.size(); i++) begin
            chk("b2b_spacing", sel_cycles[i] - sel_cycles[i-1], SETTLE + 2);
        end

        // reset in SETTLE with two commands still queued
        push(2, 5); push(5, 2); push(3, 4);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        idle(2);
        rst_n = 1'b1;
        idle(15);
        chk("post_reset_no_select", sel_cycles.size(), 0);

        // randomized traffic
        rand_bus = 1'b1;
        for (int t = 0; t < 60; t++) begin
            idle($urandom_range(0, 3));
            push($urandom_range(0, 7), $urandom_range(0, 7));
        end
        rand_bus = 1'b0;
        bus_busy_i = 1'b0;
        waitc = 0;
        while (exp_q.size() > 0 && waitc < 300) begin
            idle(1);
            waitc++;
        end
        idle(6);
        chk("final_exp_empty", exp_q.size(), 0);
        chk("final_err_empty", err_exp_q.size(), 0);
        chk("final_pending", int'(pending_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
